sdpram_be_clr: RTL and testbench



---
 rtl/sdpram_be_clr.sv | 213 +++++++++++++++++++++
 tb/tb_sdpram_be_clr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_be_clr.sv
// ---------------------------------------------------------------------------
// sdpram_be_clr
//
// Single-clock simple dual-port RAM used for the gsm_switch cell buffers.
// One write port with per-lane write enables, one read port with a read
// latency of 1 or 2 cycles, and a selectable read-during-write policy on
// same-address collisions. A clear engine zeroes the whole array after
// reset and whenever init_start is pulsed while the RAM is idle.
//
// Parameters
//   DWIDTH  data width, a multiple of LANES
//   AWIDTH  address width, depth = 2**AWIDTH
//   LANES   number of write-enable lanes, lane width LW = DWIDTH/LANES
//   RD_LAT  read latency, 1 or 2
//   BYPASS  1 = write-first on collision, 0 = read-first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   init_start  request a full-array clear
//   init_busy   clear in progress, user accesses ignored
//   wr_en       write strobe
//   wr_be       per-lane write enable, lane i = bits [i*LW +: LW]
//   wr_addr     write address
//   wr_data     write data
//   rd_en       read strobe
//   rd_addr     read address
//   rd_data     read data, holds its last value while rd_valid is low
//   rd_valid    rd_data carries the result of an accepted read
// ---------------------------------------------------------------------------
module sdpram_be_clr #(
    parameter int DWIDTH = 18,
    parameter int AWIDTH = 10,
    parameter int LANES  = 2,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    output logic              init_busy,
    input  logic              wr_en,
    input  logic [LANES-1:0]  wr_be,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid
);

    localparam int LW    = DWIDTH / LANES;
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [AWIDTH-1:0]   r_clr_cnt;
    logic                r_init_busy;
    logic                r_rd_v1;

    logic                w_ready;
    logic                w_clr_we;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_same_addr;
    logic [AWIDTH-1:0]   w_mem_addr;
    logic [DWIDTH-1:0]   w_rd_merge;

    // -----------------------------------------------------------------------
    // Control FSM: CLEAR walks the counter across every address once, READY
    // serves user traffic until a clear is requested.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // Counter wraps to 0 naturally on the last address.
                    r_clr_cnt <= r_clr_cnt + AWIDTH'(1);
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (init_start) begin
                        r_state     <= ST_CLEAR;
                        r_init_busy <= 1'b1;
                        r_clr_cnt   <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_init_busy <= 1'b1;
                    r_clr_cnt   <= '0;
                end
            endcase
        end
    end

    assign init_busy = r_init_busy;

    // -----------------------------------------------------------------------
    // Access qualification. A clear request wins over user traffic at the
    // same edge. The clear write is suppressed while rst is held so the
    // array is only touched once the engine is actually running.
    // -----------------------------------------------------------------------
    assign w_ready     = (r_state == ST_READY);
    assign w_clr_we    = (r_state == ST_CLEAR) && !rst;
    assign w_wr_acc    = w_ready && !init_start && wr_en;
    assign w_rd_acc    = w_ready && !init_start && rd_en;
    assign w_same_addr = (wr_addr == rd_addr);
    assign w_mem_addr  = w_clr_we ? r_clr_cnt : wr_addr;

    // -----------------------------------------------------------------------
    // One storage array per lane so each lane maps onto its own block RAM
    // write enable. The registered read is the RAM output register; the
    // collision bypass is resolved right after it.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LW-1:0] mem [DEPTH];
            logic [LW-1:0] r_raw;
            logic [LW-1:0] r_byp;
            logic          r_coll;
            logic          w_we;
            logic [LW-1:0] w_din;

            assign w_we  = w_clr_we || (w_wr_acc && wr_be[gi]);
            assign w_din = w_clr_we ? '0 : wr_data[gi*LW +: LW];

            // Plain read-before-write array: the read sees the old word.
            always_ff @(posedge clk) begin
                if (w_we) begin
                    mem[w_mem_addr] <= w_din;
                end
                if (w_rd_acc) begin
                    r_raw <= mem[rd_addr];
                end
            end

            // Write-first behaviour is produced by capturing the incoming
            // lane alongside the read and selecting it afterwards.
            always_ff @(posedge clk) begin
                if (w_rd_acc) begin
                    r_byp  <= wr_data[gi*LW +: LW];
                    r_coll <= (BYPASS != 0) && w_wr_acc && wr_be[gi] && w_same_addr;
                end
            end

            assign w_rd_merge[gi*LW +: LW] = r_coll ? r_byp : r_raw;
        end
    endgenerate

    // Valid for the first read stage; flushed only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_v1 <= 1'b0;
        end else begin
            r_rd_v1 <= w_rd_acc;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage selection by latency.
    // -----------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_rd_v2;
            logic [DWIDTH-1:0] r_rd_out;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_v2  <= 1'b0;
                    r_rd_out <= '0;
                end else begin
                    r_rd_v2 <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_rd_out <= w_rd_merge;
                    end
                end
            end

            assign rd_data  = r_rd_out;
            assign rd_valid = r_rd_v2;
        end else begin : g_lat1
            // The RAM output register cannot take an async reset, so the
            // data is forced to zero until the first read after reset has
            // reloaded it. It only reloads on accepted reads, so it holds.
            logic r_out_ok;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_ok <= 1'b0;
                end else if (w_rd_acc) begin
                    r_out_ok <= 1'b1;
                end
            end

            assign rd_data  = r_out_ok ? w_rd_merge : '0;
            assign rd_valid = r_rd_v1;
        end
    endgenerate

endmodule

// File: tb/tb_sdpram_be_clr.sv
// ---------------------------------------------------------------------------
// tb_sdpram_be_clr
//
// Directed bench for sdpram_be_clr. Two instances share one stimulus:
//   dut_a : RD_LAT=1, BYPASS=1
//   dut_b : RD_LAT=2, BYPASS=0
// Both use DWIDTH=18, AWIDTH=4, LANES=2 so a full clear takes 16 cycles.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sdpram_be_clr;

    logic        clk;
    logic        rst;
    logic        init_start;
    logic        wr_en;
    logic [1:0]  wr_be;
    logic [3:0]  wr_addr;
    logic [17:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        busy_a, busy_b;
    logic [17:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;

    int          n_checks;
    int          n_errors;
    logic [17:0] exp_q [16];

    sdpram_be_clr #(
        .DWIDTH(18), .AWIDTH(4), .LANES(2), .RD_LAT(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy_a),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    sdpram_be_clr #(
        .DWIDTH(18), .AWIDTH(4), .LANES(2), .RD_LAT(2), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(busy_b),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [17:0] d, input logic [1:0] be);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Single read: dut_a answers one cycle after acceptance, dut_b two.
    task automatic do_read(input string tag, input logic [3:0] a,
                           input logic [17:0] exp_a, input logic [17:0] exp_b);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, " a.valid"}, rd_valid_a, 1);
        check({tag, " a.data"},  rd_data_a,  exp_a);
        check({tag, " b.valid_early"}, rd_valid_b, 0);
        @(negedge clk);
        check({tag, " a.valid_off"}, rd_valid_a, 0);
        check({tag, " b.valid"}, rd_valid_b, 1);
        check({tag, " b.data"},  rd_data_b,  exp_b);
    endtask

    // Back-to-back reads of n addresses starting at base, expectations in exp_q.
    task automatic read_burst(input string tag, input int base, input int n);
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= n) begin
                check($sformatf("%s a.valid[%0d]", tag, k - 1), rd_valid_a, 1);
                check($sformatf("%s a.data[%0d]", tag, k - 1), rd_data_a, exp_q[k-1]);
            end
            if (k == 1) check($sformatf("%s b.valid_early", tag), rd_valid_b, 0);
            if (k >= 2) begin
                check($sformatf("%s b.valid[%0d]", tag, k - 2), rd_valid_b, 1);
                check($sformatf("%s b.data[%0d]", tag, k - 2), rd_data_b, exp_q[k-2]);
            end
            if (k == n + 1) check($sformatf("%s a.valid_end", tag), rd_valid_a, 0);
            if (k < n) begin
                rd_en = 1'b1; rd_addr = 4'(base + k);
            end else begin
                rd_en = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("%s b.valid_end", tag), rd_valid_b, 0);
    endtask

    // Counts rising edges until busy falls; optionally requires no read output.
    task automatic wait_busy(input string tag, input int exp_cycles, input bit chk_valid);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (chk_valid && (rd_valid_a || rd_valid_b)) begin
                check({tag, " valid_during_busy"}, {rd_valid_a, rd_valid_b}, 0);
            end
        end while (busy_a && cnt < 200);
        check({tag, " busy_cycles"}, cnt, exp_cycles);
        check({tag, " busy_b"}, busy_b, 0);
    endtask

    task automatic zero_exp();
        for (int i = 0; i < 16; i++) exp_q[i] = '0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; init_start = 1'b0;
        wr_en = 1'b0; wr_be = 2'b00; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy_a", busy_a, 1);
        check("rst valid_a", rd_valid_a, 0);
        check("rst data_a", rd_data_a, 0);
        check("rst valid_b", rd_valid_b, 0);
        check("rst data_b", rd_data_b, 0);

        // Clear after reset release, then all zeros.
        rst = 1'b0;
        wait_busy("rstclr", 16, 1'b0);
        zero_exp();
        read_burst("rstclr rd", 0, 16);

        // Byte-enable lanes: 0x3FFFF then lane0 cleared -> 0x3FE00.
        do_write(4'd5, 18'h3FFFF, 2'b11);
        do_write(4'd5, 18'h00000, 2'b01);
        do_write(4'd5, 18'h12345, 2'b00);
        do_read("lane", 4'd5, 18'h3FE00, 18'h3FE00);

        // Collision at addr 7: write-first (a) vs read-first (b).
        do_write(4'd7, 18'h00055, 2'b11);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 18'h2AAAA; wr_be = 2'b10;
        rd_en = 1'b1; rd_addr = 4'd7;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("coll a.data", rd_data_a, 18'h2AA55);
        @(negedge clk);
        check("coll b.data", rd_data_b, 18'h00055);
        do_read("coll after", 4'd7, 18'h2AA55, 18'h2AA55);

        // Latency: reads to 1,2,3 back to back.
        do_write(4'd1, 18'h11, 2'b11);
        do_write(4'd2, 18'h22, 2'b11);
        do_write(4'd3, 18'h33, 2'b11);
        exp_q[0] = 18'h11; exp_q[1] = 18'h22; exp_q[2] = 18'h33;
        read_burst("lat", 1, 3);

        // init_start clear with user traffic held active during busy.
        for (int i = 0; i < 16; i++) do_write(4'(i), 18'h1234, 2'b11);
        do_read("fill", 4'd9, 18'h1234, 18'h1234);
        @(negedge clk);
        init_start = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 18'h3FFFF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd2;
        @(posedge clk);
        #1;
        check("init busy_rise", busy_a, 1);
        check("init valid_a", rd_valid_a, 0);
        @(negedge clk);
        init_start = 1'b0;
        wait_busy("init", 16, 1'b1);
        wr_en = 1'b0; rd_en = 1'b0;
        zero_exp();
        read_burst("init rd", 0, 16);

        // Reset in the middle of a clear.
        for (int i = 0; i < 16; i++) do_write(4'(i), 18'h1234, 2'b11);
        do_read("pre", 4'd3, 18'h1234, 18'h1234);
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid hold_a", rd_data_a, 18'h1234);
        check("mid hold_b", rd_data_b, 18'h1234);
        #1;
        rst = 1'b1;
        #1;
        check("mid rst valid_a", rd_valid_a, 0);
        check("mid rst data_a", rd_data_a, 0);
        check("mid rst data_b", rd_data_b, 0);
        check("mid rst busy", busy_a, 1);
        @(negedge clk);
        rst = 1'b0;
        wait_busy("midclr", 16, 1'b1);
        zero_exp();
        read_burst("midclr rd", 0, 16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
